matrix_mult_sequencer: RTL and testbench

MATRIX_MULT_SEQUENCER -- requirements
Module: matrix_mult_sequencer

---
 rtl/matrix_mult_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_matrix_mult_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mult_sequencer
// Purpose  : Sequences an MxN by NxP matrix multiply over three BRAMs.
//            For each C element it streams one A row and one B column,
//            accumulates their dot product and writes it to C.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            start, abort     - run request (level), synchronous cancel
//            busy, done       - run in progress / run complete
//            a_en/a_addr/a_dout - A BRAM read port (row-major, 1-cycle latency)
//            b_en/b_addr/b_dout - B BRAM read port (column-major, 1-cycle latency)
//            c_we/c_addr/c_din  - C BRAM write port (row-major)
// Revision : 1.0 - initial release
// ============================================================================
module matrix_mult_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int M          = 2,
    parameter int N          = 2,
    parameter int P          = 2,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  a_en,
    output logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_dout,
    output logic                  b_en,
    output logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_dout,
    output logic                  c_we,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic [ACC_WIDTH-1:0]  c_din
);

    // Index counters are at least one bit wide so a dimension of 1 still works.
    localparam int c_IW = (M > 1) ? $clog2(M) : 1;
    localparam int c_JW = (P > 1) ? $clog2(P) : 1;
    localparam int c_KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [c_IW-1:0]       c_I_LAST = c_IW'(M - 1);
    localparam logic [c_JW-1:0]       c_J_LAST = c_JW'(P - 1);
    localparam logic [c_KW-1:0]       c_K_LAST = c_KW'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] c_N_A    = ADDR_WIDTH'(N);
    localparam logic [ADDR_WIDTH-1:0] c_P_A    = ADDR_WIDTH'(P);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RUN   = 3'd1;
    localparam logic [2:0] c_ST_LAST  = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]            r_state, w_state_nxt;
    logic [c_IW-1:0]       r_i, w_i_nxt;
    logic [c_JW-1:0]       r_j, w_j_nxt;
    logic [c_KW-1:0]       r_k, w_k_nxt;
    logic [ACC_WIDTH-1:0]  r_acc, w_acc_nxt;
    logic [ACC_WIDTH-1:0]  w_prod;
    logic                  w_busy_nxt, w_rd_nxt, w_wr_nxt;
    logic [ADDR_WIDTH-1:0] w_a_addr_nxt, w_b_addr_nxt, w_c_addr_nxt;

    logic                  r_busy, r_done, r_a_en, r_b_en, r_c_we;
    logic [ADDR_WIDTH-1:0] r_a_addr, r_b_addr, r_c_addr;
    logic [ACC_WIDTH-1:0]  r_c_din;

    // Operands widened before the multiply: the product then wraps modulo
    // 2^ACC_WIDTH exactly as the accumulated sum does.
    assign w_prod = ACC_WIDTH'(a_dout) * ACC_WIDTH'(b_dout);

    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_acc_nxt   = r_acc;
        case (r_state)
            c_ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = c_ST_RUN;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                    w_acc_nxt   = '0;
                end
            end
            c_ST_RUN: begin
                // Read data arriving now belongs to k-1, so nothing to add at k=0.
                if (r_k != '0) w_acc_nxt = r_acc + w_prod;
                if (r_k == c_K_LAST) w_state_nxt = c_ST_LAST;
                else                 w_k_nxt     = r_k + c_KW'(1);
            end
            c_ST_LAST: begin
                w_acc_nxt   = r_acc + w_prod;
                w_state_nxt = c_ST_WRITE;
            end
            c_ST_WRITE: begin
                w_acc_nxt = '0;
                w_k_nxt   = '0;
                if (r_j != c_J_LAST) begin
                    w_j_nxt     = r_j + c_JW'(1);
                    w_state_nxt = c_ST_RUN;
                end else begin
                    w_j_nxt = '0;
                    if (r_i != c_I_LAST) begin
                        w_i_nxt     = r_i + c_IW'(1);
                        w_state_nxt = c_ST_RUN;
                    end else begin
                        w_i_nxt     = '0;
                        w_state_nxt = c_ST_DONE;
                    end
                end
            end
            c_ST_DONE: begin
                if (abort || !start) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase

        // Abort overrides everything while a run is in flight.
        if (abort && (r_state == c_ST_RUN || r_state == c_ST_LAST ||
                      r_state == c_ST_WRITE)) begin
            w_state_nxt = c_ST_IDLE;
            w_i_nxt     = '0;
            w_j_nxt     = '0;
            w_k_nxt     = '0;
            w_acc_nxt   = '0;
        end
    end

    // Outputs are registered from the next-state view so they line up with
    // the state they describe.
    assign w_busy_nxt   = (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_LAST) ||
                          (w_state_nxt == c_ST_WRITE);
    assign w_rd_nxt     = (w_state_nxt == c_ST_RUN);
    assign w_wr_nxt     = (w_state_nxt == c_ST_WRITE);
    assign w_a_addr_nxt = ADDR_WIDTH'(w_i_nxt) * c_N_A + ADDR_WIDTH'(w_k_nxt);
    assign w_b_addr_nxt = ADDR_WIDTH'(w_j_nxt) * c_N_A + ADDR_WIDTH'(w_k_nxt);
    assign w_c_addr_nxt = ADDR_WIDTH'(w_i_nxt) * c_P_A + ADDR_WIDTH'(w_j_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_a_en   <= 1'b0;
            r_b_en   <= 1'b0;
            r_c_we   <= 1'b0;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_c_addr <= '0;
            r_c_din  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_acc    <= w_acc_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= (w_state_nxt == c_ST_DONE);
            r_a_en   <= w_rd_nxt;
            r_b_en   <= w_rd_nxt;
            r_c_we   <= w_wr_nxt;
            r_a_addr <= w_rd_nxt ? w_a_addr_nxt : '0;
            r_b_addr <= w_rd_nxt ? w_b_addr_nxt : '0;
            r_c_addr <= w_wr_nxt ? w_c_addr_nxt : '0;
            r_c_din  <= w_wr_nxt ? w_acc_nxt    : '0;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign a_en   = r_a_en;
    assign a_addr = r_a_addr;
    assign b_en   = r_b_en;
    assign b_addr = r_b_addr;
    assign c_we   = r_c_we;
    assign c_addr = r_c_addr;
    assign c_din  = r_c_din;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_matrix_mult_sequencer
// Purpose  : Self-checking bench for matrix_mult_sequencer. A schedule-based
//            reference model predicts every output on every cycle for the
//            default 2x2x2 instance; two extra instances cover the 16-bit
//            accumulator wrap and the N=1 case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_mult_sequencer;

    localparam int c_M     = 2;
    localparam int c_N     = 2;
    localparam int c_P     = 2;
    localparam int c_TOTAL = c_M * c_P * (c_N + 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int          cyc;
        int          addr;
        int unsigned din;
    } wr_t;

    // ---------------- DUT0: default parameters ----------------
    logic        start0, abort0, busy0, done0, a_en0, b_en0, c_we0;
    logic [7:0]  a_addr0, b_addr0, c_addr0;
    logic [7:0]  a_dout0 = 8'd0, b_dout0 = 8'd0;
    logic [31:0] c_din0;
    logic [7:0]  mem_a0 [256];
    logic [7:0]  mem_b0 [256];
    wr_t         wq0 [$];

    matrix_mult_sequencer u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0),
        .a_en(a_en0), .a_addr(a_addr0), .a_dout(a_dout0),
        .b_en(b_en0), .b_addr(b_addr0), .b_dout(b_dout0),
        .c_we(c_we0), .c_addr(c_addr0), .c_din(c_din0)
    );

    always @(posedge clk) begin
        if (a_en0) a_dout0 <= mem_a0[a_addr0];
        if (b_en0) b_dout0 <= mem_b0[b_addr0];
    end

    // ---------------- DUT1: 16-bit accumulator, all operands 255 ----------------
    logic        start1, busy1, done1, a_en1, b_en1, c_we1;
    logic [7:0]  a_addr1, b_addr1, c_addr1;
    logic [7:0]  a_dout1 = 8'd0, b_dout1 = 8'd0;
    logic [15:0] c_din1;
    wr_t         wq1 [$];

    matrix_mult_sequencer #(.ACC_WIDTH(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
        .busy(busy1), .done(done1),
        .a_en(a_en1), .a_addr(a_addr1), .a_dout(a_dout1),
        .b_en(b_en1), .b_addr(b_addr1), .b_dout(b_dout1),
        .c_we(c_we1), .c_addr(c_addr1), .c_din(c_din1)
    );

    always @(posedge clk) begin
        if (a_en1) a_dout1 <= 8'd255;
        if (b_en1) b_dout1 <= 8'd255;
    end

    // ---------------- DUT2: N = 1 ----------------
    logic        start2, busy2, done2, a_en2, b_en2, c_we2;
    logic [7:0]  a_addr2, b_addr2, c_addr2;
    logic [7:0]  a_dout2 = 8'd0, b_dout2 = 8'd0;
    logic [31:0] c_din2;
    logic [7:0]  mem_a2 [256];
    logic [7:0]  mem_b2 [256];
    wr_t         wq2 [$];

    matrix_mult_sequencer #(.N(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .busy(busy2), .done(done2),
        .a_en(a_en2), .a_addr(a_addr2), .a_dout(a_dout2),
        .b_en(b_en2), .b_addr(b_addr2), .b_dout(b_dout2),
        .c_we(c_we2), .c_addr(c_addr2), .c_din(c_din2)
    );

    always @(posedge clk) begin
        if (a_en2) a_dout2 <= mem_a2[a_addr2];
        if (b_en2) b_dout2 <= mem_b2[b_addr2];
    end

    // ---------------- write monitors ----------------
    always @(negedge clk) begin : mon
        wr_t w;
        if (c_we0) begin w.cyc = cyc_cnt; w.addr = int'(c_addr0); w.din = c_din0; wq0.push_back(w); end
        if (c_we1) begin w.cyc = cyc_cnt; w.addr = int'(c_addr1); w.din = 32'(c_din1); wq1.push_back(w); end
        if (c_we2) begin w.cyc = cyc_cnt; w.addr = int'(c_addr2); w.din = c_din2; wq2.push_back(w); end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Dot product of A row i and B column j, wrapping at 32 bits.
    function automatic logic [31:0] exp_sum(input int i, input int j);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < c_N; k++)
            s = s + 32'(mem_a0[i*c_N+k]) * 32'(mem_b0[j*c_N+k]);
        return s;
    endfunction

    // ---------------- reference model for DUT0 ----------------
    // A run is a fixed schedule: M*P elements of N+2 cycles each (N reads,
    // one drain cycle, one write). The model only tracks the mode and the
    // cycle offset into that schedule.
    int m_mode = 0;   // 0 idle, 1 running, 2 done
    int m_t    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_t    <= 0;
        end else begin
            case (m_mode)
                0: if (start0 && !abort0) begin m_mode <= 1; m_t <= 0; end
                1: begin
                    if (abort0) m_mode <= 0;
                    else begin
                        m_t <= m_t + 1;
                        if (m_t == c_TOTAL - 1) m_mode <= 2;
                    end
                end
                default: if (abort0 || !start0) m_mode <= 0;
            endcase
        end
    end

    always @(negedge clk) begin : cmp
        int  e, r, ii, jj;
        logic run, rd, wr;
        if (rst_n) begin
            run = (m_mode == 1);
            e   = m_t / (c_N + 2);
            r   = m_t % (c_N + 2);
            ii  = e / c_P;
            jj  = e % c_P;
            rd  = run && (r < c_N);
            wr  = run && (r == c_N + 1);
            check("busy",   busy0,   run);
            check("done",   done0,   m_mode == 2);
            check("a_en",   a_en0,   rd);
            check("b_en",   b_en0,   rd);
            check("a_addr", a_addr0, rd ? ii*c_N + r : 0);
            check("b_addr", b_addr0, rd ? jj*c_N + r : 0);
            check("c_we",   c_we0,   wr);
            check("c_addr", c_addr0, wr ? ii*c_P + jj : 0);
            check("c_din",  c_din0,  wr ? exp_sum(ii, jj) : 0);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic done_of(input int w);
        case (w)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // Counts rising edges from the accepting cycle until done is seen.
    task automatic wait_done(input int which, output int cnt);
        cnt = 0;
        while (!done_of(which) && cnt < 300) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check($sformatf("done_reached%0d", which), done_of(which), 1);
    endtask

    task automatic check_writes0(input int base, input int exp_v[4], input string tag);
        check({tag, "_count"}, wq0.size(), base + 4);
        for (int e = 0; e < 4; e++) begin
            if (base + e < wq0.size()) begin
                check({tag, "_addr"}, wq0[base+e].addr, e);
                check({tag, "_din"},  wq0[base+e].din,  exp_v[e]);
            end
        end
    endtask

    task automatic load_small();
        mem_a0[0] = 8'd1; mem_a0[1] = 8'd2; mem_a0[2] = 8'd3; mem_a0[3] = 8'd4;
        mem_b0[0] = 8'd5; mem_b0[1] = 8'd7; mem_b0[2] = 8'd6; mem_b0[3] = 8'd8;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cnt, base, ndone;
        int exp_c[4];
        int exp_ov[4];
        int exp_n1[4];
        exp_c  = '{19, 22, 43, 50};
        exp_ov = '{130050, 130050, 130050, 130050};
        exp_n1 = '{8, 10, 12, 15};

        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        for (int x = 0; x < 256; x++) begin
            mem_a0[x] = 8'd0; mem_b0[x] = 8'd0; mem_a2[x] = 8'd0; mem_b2[x] = 8'd0;
        end
        mem_a2[0] = 8'd2; mem_a2[1] = 8'd3;
        mem_b2[0] = 8'd4; mem_b2[1] = 8'd5;
        load_small();

        repeat (3) @(negedge clk);
        check("rst_busy",   busy0,   0);
        check("rst_done",   done0,   0);
        check("rst_a_en",   a_en0,   0);
        check("rst_c_we",   c_we0,   0);
        check("rst_c_din",  c_din0,  0);
        rst_n = 1'b1;
        @(negedge clk);
        check("model_c00", exp_sum(0, 0), 19);
        check("model_c11", exp_sum(1, 1), 50);

        // 2x2 reference multiply with start held
        base = wq0.size();
        start0 = 1'b1;
        wait_done(0, cnt);
        check("latency_2x2", cnt, 17);
        check_writes0(base, exp_c, "c_2x2");

        // start held in DONE: no second run
        repeat (5) @(negedge clk);
        check("hold_done",    done0,      1);
        check("hold_nowrite", wq0.size(), base + 4);
        start0 = 1'b0;
        @(negedge clk);
        check("release_done", done0, 0);
        base = wq0.size();
        start0 = 1'b1;
        wait_done(0, cnt);
        check("latency_rerun", cnt, 17);
        check_writes0(base, exp_c, "c_rerun");
        start0 = 1'b0;
        @(negedge clk);

        // abort during the second element's RUN
        base = wq0.size();
        start0 = 1'b1;
        repeat (5) @(negedge clk);
        abort0 = 1'b1;
        @(negedge clk);
        check("abort_busy", busy0, 0);
        check("abort_c_we", c_we0, 0);
        abort0 = 1'b0;
        start0 = 1'b0;
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        check("abort_never_done", ndone, 0);
        check("abort_nwrites", wq0.size(), base + 1);
        if (wq0.size() > base) begin
            check("abort_w_addr", wq0[base].addr, 0);
            check("abort_w_din",  wq0[base].din,  19);
        end

        // asynchronous reset during the WRITE of element 2
        start0 = 1'b1;
        repeat (8) @(negedge clk);
        check("pre_rst_c_we",   c_we0,   1);
        check("pre_rst_c_addr", c_addr0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",   busy0,   0);
        check("arst_done",   done0,   0);
        check("arst_a_en",   a_en0,   0);
        check("arst_b_en",   b_en0,   0);
        check("arst_c_we",   c_we0,   0);
        check("arst_a_addr", a_addr0, 0);
        check("arst_b_addr", b_addr0, 0);
        check("arst_c_addr", c_addr0, 0);
        check("arst_c_din",  c_din0,  0);
        start0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy0, 0);
        base = wq0.size();
        start0 = 1'b1;
        wait_done(0, cnt);
        check("latency_after_rst", cnt, 17);
        check_writes0(base, exp_c, "c_after_rst");
        start0 = 1'b0;
        @(negedge clk);

        // all-ones operands on a 32-bit accumulator
        for (int x = 0; x < 4; x++) begin mem_a0[x] = 8'd255; mem_b0[x] = 8'd255; end
        base = wq0.size();
        start0 = 1'b1;
        wait_done(0, cnt);
        check_writes0(base, exp_ov, "c_ones");
        start0 = 1'b0;
        @(negedge clk);

        // randomized start/abort traffic with occasional new operands
        for (int n = 0; n < 3000; n++) begin
            if (m_mode == 0 && $urandom_range(0, 7) == 0) begin
                for (int x = 0; x < 4; x++) begin
                    mem_a0[x] = 8'($urandom_range(0, 255));
                    mem_b0[x] = 8'($urandom_range(0, 255));
                end
            end
            start0 = ($urandom_range(0, 3) != 0);
            abort0 = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        start0 = 1'b0;
        abort0 = 1'b0;
        repeat (3) @(negedge clk);

        // 16-bit accumulator wraps: 2*65025 mod 65536
        start1 = 1'b1;
        wait_done(1, cnt);
        check("latency_acc16", cnt, 17);
        check("acc16_count", wq1.size(), 4);
        for (int e = 0; e < 4; e++) begin
            if (e < wq1.size()) begin
                check("acc16_addr", wq1[e].addr, e);
                check("acc16_din",  wq1[e].din,  64514);
            end
        end
        start1 = 1'b0;

        // N = 1: three cycles per element
        start2 = 1'b1;
        wait_done(2, cnt);
        check("latency_n1", cnt, 13);
        check("n1_count", wq2.size(), 4);
        for (int e = 0; e < 4; e++) begin
            if (e < wq2.size()) begin
                check("n1_addr", wq2[e].addr, e);
                check("n1_din",  wq2[e].din,  exp_n1[e]);
                if (e > 0) check("n1_spacing", wq2[e].cyc - wq2[e-1].cyc, 3);
            end
        end
        start2 = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
